min_compare_seq: RTL
====================

MIN_COMPARE_SEQ -- requirements
Module: min_compare_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the bit width of each distance operand.
REQ-002 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request to begin one six-way minimum search.
REQ-005 Ports r0..r5, input, WIDTH bits each: unsigned distance operands, sampled only when start is accepted.
REQ-006 Ports c1..c5, output, 1 bit each: comparison results of the current or last search.
REQ-007 Port min_index, output, 3 bits: index 0..5 of the minimum operand.
REQ-008 Port min_value, output, WIDTH bits: value of the minimum operand.
REQ-009 Port busy, output, 1 bit: high while a search is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-011 The FSM SHALL have the states IDLE, CMP1, CMP2, CMP3, CMP4, CMP5 and DONE.
REQ-012 start SHALL be accepted only in IDLE; accepting it captures r0..r5 into internal registers and moves to CMP1 on the same edge.
REQ-013 start in any other state SHALL be ignored, with no effect on captured operands or outputs.
REQ-014 The FSM SHALL advance one compare state per clock, from CMP1 through CMP5, then to DONE, then to IDLE unconditionally.
REQ-015 All comparisons SHALL use exactly one shared unsigned WIDTH-bit less-than comparator, multiplexed by state.
REQ-016 CMP1: c1 <= (R1 < R0); the pair minimum A and its index SHALL be registered, with R0 kept on a tie.
REQ-017 CMP2: c2 <= (R3 < R2); the pair minimum B and its index SHALL be registered, with R2 kept on a tie.
REQ-018 CMP3: c3 <= (R5 < R4); the pair minimum C and its index SHALL be registered, with R4 kept on a tie.
REQ-019 CMP4: c4 <= (B < A); the minimum AB and its index SHALL be registered, with A kept on a tie.
REQ-020 CMP5: c5 <= (C < AB); min_value and min_index SHALL be loaded with the winner, with AB kept on a tie.
REQ-021 Every comparison is strict, so ties SHALL always resolve to the lowest index.
REQ-022 min_index SHALL range over 0..5; values 6 and 7 SHALL never be produced.
REQ-023 busy SHALL be high exactly in states CMP1..CMP5.
REQ-024 done SHALL be high exactly in state DONE, which is the sixth clock after the accepting edge.
REQ-025 Latency SHALL be fixed: done is asserted 6 clocks after start is accepted.
REQ-026 Back-to-back searches SHALL be possible, with start accepted on the first cycle back in IDLE, giving 7 clocks per search.
REQ-027 c1..c5, min_index and min_value SHALL hold their last values from DONE until the next search overwrites them.
REQ-028 While a search is in progress, c1..c5 SHALL reflect partial results.
REQ-029 Consumers SHALL sample outputs only on done or in IDLE.
REQ-030 Changes on r0..r5 after acceptance SHALL NOT affect the running search.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE and clear to 0: busy, done, c1..c5, min_index, min_value and all captured and intermediate registers.
REQ-032 Reset asserted mid-search SHALL abort the search, produce no done pulse, and leave no partial results visible.
REQ-033 After reset deasserts, the first start seen in IDLE SHALL be accepted normally.

Verification
REQ-034 r = 9,7,5,3,8,1 with a start pulse -> done 6 clocks later; c1..c5 = 1,1,1,1,1; min_index = 5; min_value = 1.
REQ-035 r = 10,9,8,1,7,6 -> c1..c5 = 1,1,1,1,0; min_index = 3; min_value = 1.
REQ-036 r = 2,4,6,8,10,12 -> all c = 0; min_index = 0; min_value = 2. All operands equal to 5 -> all c = 0; min_index = 0 (tie rule).
REQ-037 start re-pulsed in CMP2 with different r -> ignored; results match the first operand set, and a single done pulse occurs.
REQ-038 reset asserted in CMP4 -> outputs 0 at once, no done pulse; a new start after release completes correctly in 6 clocks.
REQ-039 r = 0xFFFF,0xFFFF,0xFFFF,0xFFFF,0xFFFF,0xFFFE with WIDTH = 16 -> min_index = 5; min_value = 0xFFFE; c3 = 1; c5 = 1.

Source files
------------

// File: rtl/min_compare_seq.sv
// Six-way unsigned minimum search, one compare per clock through a single shared comparator.
// Latency: done pulses 6 clocks after start is accepted; one search every 7 clocks; start ignored unless idle.
module min_compare_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r0,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic [WIDTH-1:0] r4,
    input  logic [WIDTH-1:0] r5,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic [2:0]       min_index,
    output logic [WIDTH-1:0] min_value,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP1 = 3'd1,
        CMP2 = 3'd2,
        CMP3 = 3'd3,
        CMP4 = 3'd4,
        CMP5 = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t state;

    logic [WIDTH-1:0] r0_q, r1_q, r2_q, r3_q, r4_q, r5_q;
    logic [WIDTH-1:0] a_val, b_val, c_val, ab_val;
    logic [2:0]       a_idx, b_idx, c_idx, ab_idx;

    // The challenger (cmp_x) wins only when strictly smaller, so ties keep the lower index.
    logic [WIDTH-1:0] cmp_x, cmp_y, win_val;
    logic             cmp_lt;

    always_comb begin
        cmp_x = r1_q;
        cmp_y = r0_q;
        case (state)
            CMP2: begin cmp_x = r3_q;  cmp_y = r2_q;   end
            CMP3: begin cmp_x = r5_q;  cmp_y = r4_q;   end
            CMP4: begin cmp_x = b_val; cmp_y = a_val;  end
            CMP5: begin cmp_x = c_val; cmp_y = ab_val; end
            default: ;
        endcase
    end

    assign cmp_lt  = cmp_x < cmp_y;
    assign win_val = cmp_lt ? cmp_x : cmp_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            r0_q      <= '0;
            r1_q      <= '0;
            r2_q      <= '0;
            r3_q      <= '0;
            r4_q      <= '0;
            r5_q      <= '0;
            a_val     <= '0;
            b_val     <= '0;
            c_val     <= '0;
            ab_val    <= '0;
            a_idx     <= 3'd0;
            b_idx     <= 3'd0;
            c_idx     <= 3'd0;
            ab_idx    <= 3'd0;
            c1        <= 1'b0;
            c2        <= 1'b0;
            c3        <= 1'b0;
            c4        <= 1'b0;
            c5        <= 1'b0;
            min_index <= 3'd0;
            min_value <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r0_q  <= r0;
                        r1_q  <= r1;
                        r2_q  <= r2;
                        r3_q  <= r3;
                        r4_q  <= r4;
                        r5_q  <= r5;
                        busy  <= 1'b1;
                        state <= CMP1;
                    end
                end
                CMP1: begin
                    c1    <= cmp_lt;
                    a_val <= win_val;
                    a_idx <= cmp_lt ? 3'd1 : 3'd0;
                    state <= CMP2;
                end
                CMP2: begin
                    c2    <= cmp_lt;
                    b_val <= win_val;
                    b_idx <= cmp_lt ? 3'd3 : 3'd2;
                    state <= CMP3;
                end
                CMP3: begin
                    c3    <= cmp_lt;
                    c_val <= win_val;
                    c_idx <= cmp_lt ? 3'd5 : 3'd4;
                    state <= CMP4;
                end
                CMP4: begin
                    c4     <= cmp_lt;
                    ab_val <= win_val;
                    ab_idx <= cmp_lt ? b_idx : a_idx;
                    state  <= CMP5;
                end
                CMP5: begin
                    c5        <= cmp_lt;
                    min_value <= win_val;
                    min_index <= cmp_lt ? c_idx : ab_idx;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
